// File: rtl/clk_div_pkg.sv
// clk_div_pkg: controller states and divisor defaults shared by the clock divider
package clk_div_pkg;
  typedef enum logic [1:0] {STOP, RUN, RUN_PEND} state_e;
  localparam int GAME_N    = 50;
  localparam int DISPLAY_N = 4;
endpackage

// File: rtl/clk_div_ctrl_div_counter.sv
// div_counter: half-period counter producing the divided clock and its toggle strobe
// ports: run (count enable, 0 clears everything), half (active half-period),
//        boundary (last cycle of a half-period), clk_out, tick (registered outputs)
module div_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] half,
  output logic             boundary,
  output logic             clk_out,
  output logic             tick
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   cnt_inc;
  logic             clk_out_q, clk_out_d, tick_q, tick_d;
  always_comb begin
    // one extra bit so cnt + 1 never wraps before the compare
    cnt_inc   = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    boundary  = run && (cnt_inc == {1'b0, half});
    cnt_d     = (!run || boundary) ? '0 : cnt_inc[WIDTH-1:0];
    clk_out_d = run ? (clk_out_q ^ boundary) : 1'b0;
    tick_d    = boundary;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end
  assign clk_out = clk_out_q;
  assign tick    = tick_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time reprogrammable clock divider with glitch-free divisor handover
// ports: en (run enable), div_in/div_load (divisor request), div_ack (request now active),
//        div_cur (active half-period), pend (load waiting for a boundary),
//        clk_out (period 2*div_cur), tick (strobe on every clk_out toggle)
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int DEFAULT_N = GAME_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic [WIDTH-1:0] div_cur,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d, pend_q, pend_d, div_san;
  logic             ack_q, ack_d, run, boundary;
  assign div_san = (div_in == '0) ? WIDTH'(1) : div_in;
  assign run     = (state_q != STOP) && en;
  always_comb begin
    state_d   = state_q;
    div_cur_d = div_cur_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;
    if (state_q == STOP) begin
      state_d = en ? RUN : STOP;
      if (div_load) begin
        div_cur_d = div_san;
        ack_d     = 1'b1;
      end
    end else if (!en) begin
      // stopping flushes any request straight into div_cur; the newest one wins
      state_d = STOP;
      if (div_load || state_q == RUN_PEND) begin
        div_cur_d = div_load ? div_san : pend_q;
        ack_d     = 1'b1;
      end
    end else begin
      // div_cur only changes as cnt returns to 0, so a shorter divisor cannot be overrun
      if (state_q == RUN_PEND && boundary) begin
        div_cur_d = pend_q;
        ack_d     = 1'b1;
        state_d   = RUN;
      end
      if (div_load) begin
        pend_d  = div_san;
        state_d = RUN_PEND;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= STOP;
      div_cur_q <= WIDTH'(DEFAULT_N);
      pend_q    <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
    end
  end
  div_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .half     (div_cur_q),
    .boundary (boundary),
    .clk_out  (clk_out),
    .tick     (tick)
  );
  assign div_ack = ack_q;
  assign div_cur = div_cur_q;
  assign pend    = (state_q == RUN_PEND);
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and random checks of clk_div_ctrl against a half-period countdown model
module tb_clk_div_ctrl;
  localparam int W = 6;
  localparam int DEF = 50;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, div_load = 1'b0;
  logic [W-1:0] div_in = '0;
  logic div_ack, pend, clk_out, tick;
  logic [W-1:0] div_cur;
  int checks = 0, errors = 0;
  bit m_run, m_lvl, m_tick, m_ack;
  int m_rem;
  logic [W-1:0] m_cur;
  logic [W-1:0] m_pq[$];

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_N(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .div_ack(div_ack), .div_cur(div_cur), .pend(pend), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic logic [W+3:0] obs();
    return {clk_out, tick, div_ack, pend, div_cur};
  endfunction

  function automatic logic [W+3:0] exp_v();
    return {m_lvl, m_tick, m_ack, m_pq.size() != 0, m_cur};
  endfunction

  // model: each half-period is a countdown loaded with the active divisor;
  // requests wait in a one-deep last-wins queue until the countdown expires
  task automatic step();
    logic [W-1:0] san;
    @(posedge clk);
    san = (div_in == '0) ? W'(1) : div_in;
    m_ack = 0;
    m_tick = 0;
    if (rst) begin
      m_run = 0; m_lvl = 0; m_cur = W'(DEF); m_pq.delete();
    end else if (!m_run) begin
      if (div_load) begin m_cur = san; m_ack = 1; end
      if (en) begin m_run = 1; m_rem = int'(m_cur); end
    end else if (!en) begin
      m_run = 0; m_lvl = 0;
      if (div_load) begin m_pq.delete(); m_pq.push_back(san); end
      if (m_pq.size() != 0) begin m_cur = m_pq.pop_front(); m_ack = 1; end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_lvl = !m_lvl; m_tick = 1;
        if (m_pq.size() != 0) begin m_cur = m_pq.pop_front(); m_ack = 1; end
        m_rem = int'(m_cur);
      end
      if (div_load) begin m_pq.delete(); m_pq.push_back(san); end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; div_load = 1; div_in = 5;
    step(); step();
    checks++;
    if (obs() !== {4'b0000, W'(DEF)}) begin errors++; $display("FAIL reset_vals got %h exp %h", obs(), {4'b0000, W'(DEF)}); end
    rst = 0; en = 0; div_load = 0;
    step();
    checks++;
    if (obs() !== exp_v()) begin errors++; $display("FAIL reset_idle got %h exp %h", obs(), exp_v()); end
  endtask

  task automatic test_defaults();
    int n, p, acks;
    bit prev;
    en = 1;
    step();
    n = 0;
    while (!clk_out && n < 200) begin
      step(); n++;
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL dflt_model cyc %0d got %h exp %h", n, obs(), exp_v()); end
    end
    checks++;
    if (n !== DEF) begin errors++; $display("FAIL dflt_first_rise got %0d exp %0d", n, DEF); end
    p = 0; acks = 0; prev = clk_out;
    do begin
      prev = clk_out; step(); p++; acks += div_ack;
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL dflt_period_model cyc %0d got %h exp %h", p, obs(), exp_v()); end
    end while (!(clk_out && !prev) && p < 300);
    checks++;
    if (p !== 2 * DEF) begin errors++; $display("FAIL dflt_period got %0d exp %0d", p, 2 * DEF); end
    checks++;
    if (acks !== 0 || div_cur !== W'(DEF)) begin errors++; $display("FAIL dflt_noack acks %0d div_cur %0d exp 0 %0d", acks, div_cur, DEF); end
  endtask

  task automatic test_load_run();
    int n, c;
    bit lvl;
    repeat (10) step();
    div_load = 1; div_in = 3;
    step();
    div_load = 0;
    checks++;
    if (pend !== 1'b1 || div_cur !== W'(DEF)) begin errors++; $display("FAIL load_pend got %b/%0d exp 1/%0d", pend, div_cur, DEF); end
    n = 0;
    while (!div_ack && n < 100) begin
      step(); n++;
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL load_model cyc %0d got %h exp %h", n, obs(), exp_v()); end
    end
    checks++;
    if (!(div_ack && tick && !pend && div_cur == 3)) begin errors++; $display("FAIL load_ack ack %b tick %b pend %b div_cur %0d exp 1 1 0 3", div_ack, tick, pend, div_cur); end
    for (int h = 0; h < 2; h++) begin
      c = 0; lvl = clk_out;
      while (clk_out == lvl && c < 20) begin step(); c++; end
      checks++;
      if (c !== 3) begin errors++; $display("FAIL load_level%0d got %0d exp 3", h, c); end
    end
  endtask

  task automatic test_back_to_back();
    int n, acks, c;
    bit lvl;
    n = 0;
    while (!tick && n < 20) begin step(); n++; end
    div_load = 1; div_in = 7;
    step();
    div_in = 4;
    step();
    div_load = 0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      step(); acks += div_ack;
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL b2b_model cyc %0d got %h exp %h", i, obs(), exp_v()); end
    end
    checks++;
    if (acks !== 1 || div_cur !== 4) begin errors++; $display("FAIL b2b_ack acks %0d div_cur %0d exp 1 4", acks, div_cur); end
    lvl = clk_out; c = 0;
    while (clk_out == lvl && c < 20) begin step(); c++; end
    lvl = clk_out; c = 0;
    while (clk_out == lvl && c < 20) begin step(); c++; end
    checks++;
    if (c !== 4) begin errors++; $display("FAIL b2b_level got %0d exp 4", c); end
  endtask

  task automatic test_zero_stop();
    bit prev;
    en = 0;
    step();
    checks++;
    if (clk_out !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL stop_outs got %b%b exp 00", clk_out, tick); end
    div_load = 1; div_in = 0;
    step();
    div_load = 0;
    checks++;
    if (div_ack !== 1'b1 || div_cur !== 1) begin errors++; $display("FAIL zero_clamp ack %b div_cur %0d exp 1 1", div_ack, div_cur); end
    en = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      prev = clk_out; step();
      checks++;
      if (tick !== 1'b1 || clk_out === prev || obs() !== exp_v()) begin errors++; $display("FAIL n1_toggle cyc %0d got %h exp %h", i, obs(), exp_v()); end
    end
  endtask

  task automatic test_en_drop();
    int n;
    en = 0; step();
    div_load = 1; div_in = 6; step();
    div_load = 0; en = 1; step();
    repeat (8) step();
    div_load = 1; div_in = 9; step();
    div_load = 0;
    checks++;
    if (pend !== 1'b1) begin errors++; $display("FAIL drop_pend got %b exp 1", pend); end
    en = 0; step();
    checks++;
    if (obs() !== {4'b0010, W'(9)} || obs() !== exp_v()) begin errors++; $display("FAIL drop_apply got %h exp %h", obs(), {4'b0010, W'(9)}); end
    en = 1; step();
    n = 0;
    while (!clk_out && n < 100) begin step(); n++; end
    checks++;
    if (n !== 9) begin errors++; $display("FAIL drop_rerise got %0d exp 9", n); end
  endtask

  task automatic test_rst_pend();
    int acks;
    repeat (3) step();
    div_load = 1; div_in = 2; step();
    div_load = 0;
    checks++;
    if (pend !== 1'b1) begin errors++; $display("FAIL rstp_pend got %b exp 1", pend); end
    rst = 1; step();
    rst = 0;
    checks++;
    if (obs() !== {4'b0000, W'(DEF)}) begin errors++; $display("FAIL rstp_vals got %h exp %h", obs(), {4'b0000, W'(DEF)}); end
    acks = 0;
    for (int i = 0; i < 120; i++) begin
      step(); acks += div_ack;
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL rstp_model cyc %0d got %h exp %h", i, obs(), exp_v()); end
    end
    checks++;
    if (acks !== 0 || div_cur !== W'(DEF)) begin errors++; $display("FAIL rstp_noack acks %0d div_cur %0d exp 0 %0d", acks, div_cur, DEF); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 500) == 0;
      en = ($urandom % 40) != 0;
      div_load = ($urandom % 8) == 0;
      div_in = ($urandom % 4 == 0) ? W'($urandom_range(0, 63)) : W'($urandom_range(0, 6));
      step();
      checks++;
      if (obs() !== exp_v()) begin errors++; $display("FAIL rand_model cyc %0d got %h exp %h", i, obs(), exp_v()); end
    end
    rst = 0; en = 0; div_load = 0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_load_run();
    test_back_to_back();
    test_zero_stop();
    test_en_drop();
    test_rst_pend();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
